bist_signature_ctl: RTL

On-chip BIST response compactor and sequencer that sits directly downstream of the circuit-under-test (CUT) inside `chip`. It steps the upstream pattern generator through a fixed-length run and compresses the CUT primary outputs into a multiple-input signature register (MISR). At the end of the run it compares the signature against a golden constant and reports the result on `bistdone`/`bistpass`. In system mode (`bistmode=0`) it is idle and transparent.

---
 rtl/bist_signature_ctl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bist_signature_ctl.sv
// -----------------------------------------------------------------------------
// bist_signature_ctl
//
// BIST sequencer and response compactor that sits right after the
// circuit-under-test. A run steps the pattern generator through NUM_PATTERNS
// patterns and folds each CUT response into a multiple-input signature register
// (MISR). When the run ends, the MISR is compared with the golden SIGNATURE.
// With bistmode low the block stays idle and the chip PIs drive the CUT.
//
// Parameters
//   PO_WIDTH       CUT primary-output width, which is also the MISR width
//   NUM_PATTERNS   number of cycles the pattern generator is advanced
//   CAPTURE_DELAY  CUT latency from pattern applied to response valid
//   MISR_POLY      feedback tap mask, XORed in when the MISR MSB is set
//   MISR_SEED      MISR value loaded at the start of every run
//   SIGNATURE      golden signature of the fault-free CUT
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous reset, active low
//   bistmode     1 requests a BIST run, 0 selects system mode
//   cut_po       CUT primary outputs
//   tpg_load     one-cycle pulse that loads the pattern generator seed
//   tpg_en       pattern generator advance enable
//   bist_active  steers the CUT input mux to the pattern generator
//   signature    live MISR contents, for debug
//   bistdone     run complete; held until reset or bistmode falls
//   bistpass     signature matched; meaningful only while bistdone is high
// -----------------------------------------------------------------------------
module bist_signature_ctl #(
  parameter int                  PO_WIDTH      = 49,
  parameter int                  NUM_PATTERNS  = 2000,
  parameter int                  CAPTURE_DELAY = 2,
  parameter logic [PO_WIDTH-1:0] MISR_POLY     = 49'h1_0000_0000_0201,
  parameter logic [PO_WIDTH-1:0] MISR_SEED     = '0,
  parameter logic [PO_WIDTH-1:0] SIGNATURE     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bistmode,
  input  logic [PO_WIDTH-1:0] cut_po,
  output logic                tpg_load,
  output logic                tpg_en,
  output logic                bist_active,
  output logic [PO_WIDTH-1:0] signature,
  output logic                bistdone,
  output logic                bistpass
);

  // The counter is sized to reach NUM_PATTERNS+CAPTURE_DELAY, so it cannot
  // wrap during RUN. It increments on the final RUN cycle as well.
  localparam int CNT_W = $clog2(NUM_PATTERNS + CAPTURE_DELAY + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS + CAPTURE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_NP   = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W:0]   CAP_REF  = (CNT_W + 1)'(CAPTURE_DELAY);
  localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt;
  logic [PO_WIDTH-1:0] misr;
  logic                pass_q;
  logic                cap_window;
  logic                capture;

  // One MISR step: shift left, fold in the taps when the MSB drops out, then
  // XOR in the CUT response (all arithmetic is modulo 2).
  function automatic logic [PO_WIDTH-1:0] misr_step(
    input logic [PO_WIDTH-1:0] cur,
    input logic [PO_WIDTH-1:0] po
  );
    logic [PO_WIDTH-1:0] fb;
    fb = cur[PO_WIDTH-1] ? MISR_POLY : '0;
    return {cur[PO_WIDTH-2:0], 1'b0} ^ fb ^ po;
  endfunction

  // The test cnt >= CAPTURE_DELAY is written as cnt+1 > CAPTURE_DELAY in one
  // extra bit. This keeps the comparison meaningful when CAPTURE_DELAY is 0.
  assign cap_window = (({1'b0, cnt} + CNT_ONE) > CAP_REF);
  assign capture    = (state == S_RUN) && bistmode && cap_window;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode. Losing bistmode in any active state returns to IDLE.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (bistmode) state_d = S_SEED;
      S_SEED:    state_d = bistmode ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!bistmode)             state_d = S_IDLE;
        else if (cnt == CNT_LAST)  state_d = S_COMPARE;
      end
      S_COMPARE: state_d = bistmode ? S_DONE : S_IDLE;
      S_DONE:    if (!bistmode) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode. The outputs depend only on state, the counter and the
  // registered pass flag, never directly on cut_po.
  always_comb begin
    tpg_load    = 1'b0;
    tpg_en      = 1'b0;
    bist_active = 1'b0;
    bistdone    = 1'b0;
    case (state)
      S_SEED: begin
        tpg_load    = 1'b1;
        bist_active = 1'b1;
      end
      S_RUN: begin
        bist_active = 1'b1;
        tpg_en      = (cnt < CNT_NP);
      end
      S_COMPARE: bist_active = 1'b1;
      S_DONE:    bistdone    = 1'b1;
      default: ;
    endcase
  end

  assign bistpass  = pass_q;
  assign signature = misr;

  // Run counter, MISR and pass flag. The MISR holds its value outside RUN, so
  // it stays frozen in DONE and after an abort until SEED reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      misr   <= MISR_SEED;
      pass_q <= 1'b0;
    end else begin
      if ((state == S_RUN) && bistmode) cnt <= cnt + CNT_W'(1);
      else                              cnt <= '0;

      if ((state == S_SEED) && bistmode) misr <= MISR_SEED;
      else if (capture)                  misr <= misr_step(misr, cut_po);

      if ((state == S_COMPARE) && bistmode)  pass_q <= (misr == SIGNATURE);
      else if (!((state == S_DONE) && bistmode)) pass_q <= 1'b0;
    end
  end

endmodule
